// File: rtl/uart_program_loader.sv
// ---------------------------------------------------------------------------
// uart_program_loader
//
// Boot loader that sits between a UART receiver and the instruction memory
// of a single-cycle core. It receives a frame of bytes, assembles them into
// little-endian 32-bit words, and writes each word to instruction memory.
// The core is held in reset until a complete frame with a good checksum has
// been loaded.
//
// Frame layout (byte order on the wire):
//   0xA5 header, count_lo, count_hi, count*4 payload bytes, checksum
// The checksum is the 8-bit wrapping sum of count_lo, count_hi and every
// payload byte. The header and the checksum byte itself are not included.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   rx_data       in   [7:0]  received byte, qualified by rx_valid
//   rx_valid      in   one-cycle strobe per received byte
//   mem_we        out  instruction-memory write strobe, one cycle per word
//   mem_addr      out  [31:0] byte address of the word being written
//   mem_wdata     out  [31:0] word being written
//   core_hold     out  1 = keep the core in reset
//   done          out  frame loaded with good checksum (sticky until rst)
//   error         out  frame aborted (sticky until the next header byte)
//   err_code      out  [1:0] 0 none, 1 timeout, 2 count too large, 3 bad checksum
//   words_loaded  out  [15:0] words written in the current or last frame
//
// Handshake: a byte is consumed in every cycle where rx_valid is high. There
// is no backpressure, so the loader accepts a byte on every cycle, including
// the cycle in which a completed word is being written (mem_we high).
// ---------------------------------------------------------------------------
module uart_program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
  parameter int          MAX_WORDS      = 64,
  parameter int          TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  localparam logic [7:0]  HEADER     = 8'hA5;
  localparam logic [15:0] MAX_W      = 16'(MAX_WORDS);
  // The timeout fires on the edge where the idle count would reach
  // TIMEOUT_CYCLES-1, so the comparison is made one count earlier.
  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 2);

  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_COUNT    = 2'd2;
  localparam logic [1:0] ERR_CHECKSUM = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
  logic [7:0]  checksum;
  logic [31:0] timer;

  logic        in_frame;
  logic        in_frame_next;
  logic        err_set;
  logic [1:0]  err_val;
  logic [15:0] count_full;
  logic [15:0] last_word;

  // States in which the inter-byte timer is running.
  assign in_frame      = (state == S_CNT_LO) || (state == S_CNT_HI) ||
                         (state == S_DATA)   || (state == S_CHECK);
  assign in_frame_next = (state_next == S_CNT_LO) || (state_next == S_CNT_HI) ||
                         (state_next == S_DATA)   || (state_next == S_CHECK);

  // Full word count as it will be once the current byte lands in count_hi.
  assign count_full = {rx_data, count[7:0]};
  assign last_word  = count - 16'd1;

  assign core_hold = (state != S_DONE);
  assign done      = (state == S_DONE);
  assign error     = (state == S_ERR);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    err_val    = 2'd0;

    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == HEADER)) state_next = S_CNT_LO;
      end
      S_CNT_LO: begin
        if (rx_valid) state_next = S_CNT_HI;
      end
      S_CNT_HI: begin
        if (rx_valid) begin
          if (count_full > MAX_W) begin
            state_next = S_ERR;
            err_set    = 1'b1;
            err_val    = ERR_COUNT;
          end else if (count_full == 16'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid && (byte_idx == 2'd3) && (word_idx == last_word)) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (rx_valid) begin
          if (rx_data == checksum) begin
            state_next = S_DONE;
          end else begin
            state_next = S_ERR;
            err_set    = 1'b1;
            err_val    = ERR_CHECKSUM;
          end
        end
      end
      S_DONE: begin
        state_next = S_DONE;
      end
      S_ERR: begin
        if (rx_valid && (rx_data == HEADER)) state_next = S_CNT_LO;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A byte arriving in the expiry cycle wins over the timeout, which is
    // why the timeout only applies when rx_valid is low.
    if (in_frame && !rx_valid && (timer == TIMER_LAST)) begin
      state_next = S_ERR;
      err_set    = 1'b1;
      err_val    = ERR_TIMEOUT;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: count, checksum, word assembly, memory write, timer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= BASE_ADDR;
      mem_wdata    <= 32'd0;
      err_code     <= 2'd0;
      words_loaded <= 16'd0;
      count        <= 16'd0;
      word_idx     <= 16'd0;
      byte_idx     <= 2'd0;
      word_buf     <= 24'd0;
      checksum     <= 8'd0;
      timer        <= 32'd0;
    end else begin
      mem_we <= 1'b0;

      if (in_frame_next && !rx_valid) begin
        timer <= timer + 32'd1;
      end else begin
        timer <= 32'd0;
      end

      if (err_set) begin
        err_code <= err_val;
      end

      case (state)
        S_IDLE, S_ERR: begin
          // A header starts a fresh frame from either waiting state.
          if (rx_valid && (rx_data == HEADER)) begin
            err_code     <= 2'd0;
            words_loaded <= 16'd0;
            count        <= 16'd0;
            word_idx     <= 16'd0;
            byte_idx     <= 2'd0;
            checksum     <= 8'd0;
          end
        end
        S_CNT_LO: begin
          if (rx_valid) begin
            count[7:0] <= rx_data;
            checksum   <= checksum + rx_data;
          end
        end
        S_CNT_HI: begin
          if (rx_valid) begin
            count[15:8] <= rx_data;
            checksum    <= checksum + rx_data;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            checksum <= checksum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // The top byte goes straight to the write port; the lower
              // three come from the assembly buffer. mem_addr/mem_wdata only
              // change here, so they hold while mem_we is low.
              mem_we       <= 1'b1;
              mem_addr     <= BASE_ADDR + {14'd0, word_idx, 2'b00};
              mem_wdata    <= {rx_data, word_buf};
              word_idx     <= word_idx + 16'd1;
              words_loaded <= words_loaded + 16'd1;
            end else begin
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= rx_data;
                2'd1:    word_buf[15:8]  <= rx_data;
                default: word_buf[23:16] <= rx_data;
              endcase
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// ---------------------------------------------------------------------------
// tb_uart_program_loader
//
// Bench for the UART program loader, built with a short timeout (100 cycles)
// so the timeout boundary can be exercised. Expected memory writes come from
// a frame-level reference model that parses a whole byte list at once; the
// monitor compares every observed write against that expected queue.
// ---------------------------------------------------------------------------
module tb_uart_program_loader;

  localparam logic [31:0] BASE    = 32'h0040_0000;
  localparam int          MAXW    = 64;
  localparam int          TIMEOUT = 100;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0]  b[16];
    int          len;
    logic        exp_done;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [15:0] exp_words;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [1:0]  err_code;
  logic [15:0] words_loaded;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];

  uart_program_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MAXW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .err_code     (err_code),
    .words_loaded (words_loaded)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_status(input logic e_done, input logic e_err,
                              input logic [1:0] e_code, input logic [15:0] e_words);
    chk("done", done, e_done);
    chk("error", error, e_err);
    chk("err_code", err_code, e_code);
    chk("words_loaded", words_loaded, e_words);
    chk("core_hold", core_hold, !e_done);
    chk("pending_writes", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got %0h:%0h expected none", mem_addr, mem_wdata);
      end else begin
        chk("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  // Parses a complete frame (header first) and predicts writes and status.
  task automatic model_frame(input bq_t f, output logic m_done, output logic m_err,
                             output logic [1:0] m_code, output logic [15:0] m_words);
    int cnt;
    logic [7:0] sum;
    logic [31:0] w;
    m_done = 1'b0; m_err = 1'b0; m_code = 2'd0; m_words = 16'd0;
    cnt = int'(f[1]) + 256 * int'(f[2]);
    if (cnt > MAXW) begin
      m_err = 1'b1; m_code = 2'd2;
      return;
    end
    sum = f[1] + f[2];
    for (int k = 0; k < cnt; k++) begin
      w = {f[6+4*k], f[5+4*k], f[4+4*k], f[3+4*k]};
      for (int j = 0; j < 4; j++) sum = sum + f[3+4*k+j];
      exp_q.push_back({BASE + 32'(4 * k), w});
    end
    m_words = 16'(cnt);
    if (f[3+4*cnt] == sum) m_done = 1'b1;
    else begin m_err = 1'b1; m_code = 2'd3; end
  endtask

  task automatic make_frame(input int cnt, input bit corrupt, output bq_t f);
    logic [7:0] sum;
    logic [7:0] b;
    f = {};
    f.push_back(8'hA5);
    f.push_back(cnt[7:0]);
    f.push_back(cnt[15:8]);
    if (cnt <= MAXW) begin
      sum = cnt[7:0] + cnt[15:8];
      for (int k = 0; k < 4 * cnt; k++) begin
        b = 8'($urandom_range(0, 255));
        f.push_back(b);
        sum = sum + b;
      end
      f.push_back(corrupt ? sum + 8'd1 : sum);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // gap = idle cycles between bytes; 0 means back-to-back.
  task automatic send_frame(input bq_t f, input int gap);
    for (int i = 0; i < f.size(); i++) begin
      @(negedge clk);
      rx_data = f[i];
      rx_valid = 1'b1;
      if (gap > 0) begin
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic load_vec(output vec_t v, input bq_t q, input logic d, input logic e,
                          input logic [1:0] c, input logic [15:0] w);
    for (int i = 0; i < 16; i++) v.b[i] = (i < q.size()) ? q[i] : 8'h00;
    v.len = q.size();
    v.exp_done = d; v.exp_err = e; v.exp_code = c; v.exp_words = w;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  bq_t  f;
  bq_t  f_good;
  logic m_done, m_err;
  logic [1:0] m_code;
  logic [15:0] m_words;

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;

    load_vec(vecs[0], '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h6F, 8'h00, 8'h00, 8'h00, 8'h84}, 1'b1, 1'b0, 2'd0, 16'd2);
    load_vec(vecs[1], '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h6F, 8'h00, 8'h00, 8'h00, 8'h85}, 1'b0, 1'b1, 2'd3, 16'd2);
    load_vec(vecs[2], '{8'hA5, 8'h41, 8'h00}, 1'b0, 1'b1, 2'd2, 16'd0);
    load_vec(vecs[3], '{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b0, 2'd0, 16'd0);
    load_vec(vecs[4], '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h0F},
             1'b1, 1'b0, 2'd0, 16'd1);
    load_vec(vecs[5], '{8'hA5, 8'h00, 8'h01}, 1'b0, 1'b1, 2'd2, 16'd0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, BASE);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_status(1'b0, 1'b0, 2'd0, 16'd0);

    // Table-driven frames, each from reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      f = {};
      for (int j = 0; j < vecs[i].len; j++) f.push_back(vecs[i].b[j]);
      model_frame(f, m_done, m_err, m_code, m_words);
      send_frame(f, 1);
      settle();
      check_status(vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_code, vecs[i].exp_words);
    end
    // Test-1 writes, stated explicitly
    do_reset();
    exp_q.push_back({32'h0040_0000, 32'h0000_0013});
    exp_q.push_back({32'h0040_0004, 32'h0000_006F});
    f_good = {};
    for (int j = 0; j < vecs[0].len; j++) f_good.push_back(vecs[0].b[j]);
    send_frame(f_good, 2);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd2);

    // Bad checksum, then resend of the good frame without reset
    do_reset();
    f = {};
    for (int j = 0; j < vecs[1].len; j++) f.push_back(vecs[1].b[j]);
    model_frame(f, m_done, m_err, m_code, m_words);
    send_frame(f, 1);
    settle();
    check_status(1'b0, 1'b1, 2'd3, 16'd2);
    model_frame(f_good, m_done, m_err, m_code, m_words);
    send_frame(f_good, 0);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd2);
    // Bytes after done are ignored (no writes expected)
    send_frame(f_good, 0);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd2);

    // Count too large, then empty frame without reset
    do_reset();
    send_frame('{8'hA5, 8'h41, 8'h00}, 1);
    settle();
    check_status(1'b0, 1'b1, 2'd2, 16'd0);
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 1);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd0);

    // Timeout expires 99 edges after the last byte
    do_reset();
    send_frame('{8'hA5, 8'h01, 8'h00}, 0);
    send_byte(8'hAA);
    repeat (TIMEOUT - 2) @(posedge clk);
    #1;
    chk("timeout_early", {error, err_code}, {1'b0, 2'd0});
    @(posedge clk);
    #1;
    chk("timeout_fire", {error, err_code}, {1'b1, 2'd1});
    chk("timeout_hold", core_hold, 1'b1);

    // A byte in the expiry cycle keeps the frame alive
    do_reset();
    send_frame('{8'hA5, 8'h01, 8'h00}, 0);
    send_byte(8'hAA);
    repeat (TIMEOUT - 2) @(negedge clk);
    rx_data = 8'hBB;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("timeout_saved", error, 1'b0);
    exp_q.push_back({BASE, 32'hDDCC_BBAA});
    send_frame('{8'hCC, 8'hDD, 8'h0F}, 0);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd1);

    // Back-to-back 4-word frame
    do_reset();
    make_frame(4, 1'b0, f);
    model_frame(f, m_done, m_err, m_code, m_words);
    send_frame(f, 0);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd4);

    // Largest legal count
    do_reset();
    make_frame(MAXW, 1'b0, f);
    model_frame(f, m_done, m_err, m_code, m_words);
    send_frame(f, 0);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'(MAXW));

    // Reset in DATA after two words
    do_reset();
    exp_q.push_back({BASE, 32'h0403_0201});
    exp_q.push_back({BASE + 32'd4, 32'h0807_0605});
    send_frame('{8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                 8'h05, 8'h06, 8'h07, 8'h08}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", mem_we, 1'b0);
    chk("midrst_mem_addr", mem_addr, BASE);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    chk("midrst_words", words_loaded, 16'd0);
    chk("midrst_flags", {core_hold, done, error, err_code}, {1'b1, 1'b0, 1'b0, 2'd0});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    make_frame(3, 1'b0, f);
    model_frame(f, m_done, m_err, m_code, m_words);
    send_frame(f, 1);
    settle();
    check_status(1'b1, 1'b0, 2'd0, 16'd3);

    // Randomised frames against the model
    for (int it = 0; it < 30; it++) begin
      int cnt;
      int nn;
      logic [7:0] nb;
      do_reset();
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == 8'hA5) nb = 8'h5A;
        send_byte(nb);
      end
      cnt = ($urandom_range(0, 9) == 9) ? $urandom_range(65, 300) : $urandom_range(0, 8);
      make_frame(cnt, ($urandom_range(0, 3) == 0), f);
      model_frame(f, m_done, m_err, m_code, m_words);
      send_frame(f, $urandom_range(0, 3));
      settle();
      check_status(m_done, m_err, m_code, m_words);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
